// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared definitions for the rv32im memory stage.
//   - RV32I load/store funct3 encodings
//   - memory-stage FSM state and the latched result kind reported in RESP
//   - base byte-enable patterns for byte/half/word stores
//   - is_illegal(): rejects encodings that have no defined memory access
package rv_mem_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Byte enables before shifting into the addressed lane
  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // What the RESP cycle reports; RES_OK is a completed store (no pulse).
  typedef enum logic [1:0] {
    RES_OK       = 2'd0,
    RES_LOAD     = 2'd1,
    RES_MISALIGN = 2'd2,
    RES_ERR      = 2'd3
  } result_t;

  function automatic logic is_illegal(input logic load, input logic store,
                                      input logic [2:0] funct3);
    logic bad;
    bad = 1'b0;
    if (load && store)
      bad = 1'b1;
    else if (load)
      bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else if (store)
      bad = (funct3 > SW);
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load extraction.
//   rdata     in  32  raw word returned by data memory
//   offset    in  2   byte offset of the access within the word
//   funct3    in  3   load size/sign (LB, LH, LW, LBU, LHU)
//   load_data out 32  selected byte/half/word, sign- or zero-extended
module mem_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_data = rdata;
    shifted   = rdata >> {offset, 3'b000};
    lane_b    = shifted[7:0];
    // Halfword accesses are aligned, so only offset[1] selects the lane.
    lane_h    = offset[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      load_data = {{24{lane_b[7]}}, lane_b};
      LBU:     load_data = {24'h0, lane_b};
      LH:      load_data = {{16{lane_h[15]}}, lane_h};
      LHU:     load_data = {16'h0, lane_h};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage of the rv32im pipeline.
//   Accepts a load/store from EX/MEM (mem_valid_i/mem_load_i/mem_store_i,
//   funct3_i, addr_i, store_data_i), runs it on the dmem valid/grant/rvalid
//   port, and holds the pipeline with stall_o until the access completes.
//   In the RESP cycle exactly one of load_valid_o, misalign_o or err_o pulses
//   (a good store pulses none). load_data_o holds the last load result.
//   Faulty accesses never reach the memory port. An optional watchdog
//   (TIMEOUT_CYCLES != 0) aborts a stuck access with err_o.
module mem_access_unit
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic        mem_load_i,
  input  logic        mem_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  localparam bit             WDOG_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  result_t     result_q, result_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]  offset_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q, wdata_fmt;
  logic [3:0]  wstrb_q, wstrb_fmt;
  logic [31:0] load_data_q, aligned;

  logic start, illegal, misaligned, timeout;

  assign start      = mem_valid_i & (mem_load_i | mem_store_i);
  assign illegal    = is_illegal(mem_load_i, mem_store_i, funct3_i);
  assign misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
  // Last permitted cycle in REQ/WAIT; completion in that cycle still wins.
  assign timeout    = WDOG_EN && (cnt_q == CNT_LAST);

  // Store lane replication and byte enables.
  always_comb begin
    wdata_fmt = store_data_i;
    wstrb_fmt = WSTRB_W;
    case (funct3_i[1:0])
      2'b00: begin
        wdata_fmt = {4{store_data_i[7:0]}};
        wstrb_fmt = WSTRB_B << addr_i[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{store_data_i[15:0]}};
        wstrb_fmt = WSTRB_H << {addr_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  mem_load_align u_align (
    .rdata     (dmem_rdata_i),
    .offset    (offset_q),
    .funct3    (funct3_q),
    .load_data (aligned)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state_q  <= IDLE;
      result_q <= RES_OK;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal) begin
            state_d  = RESP;
            result_d = RES_ERR;
          end else if (misaligned) begin
            state_d  = RESP;
            result_d = RES_MISALIGN;
          end else begin
            state_d  = REQ;
            result_d = mem_store_i ? RES_OK : RES_LOAD;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = store_q ? RESP : WAIT;
        end else if (timeout) begin
          state_d  = RESP;
          result_d = RES_ERR;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d  = RESP;
          result_d = RES_ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    misalign_o   = 1'b0;
    err_o        = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_wdata_o = 32'h0;
    dmem_wstrb_o = WSTRB_NONE;
    case (state_q)
      IDLE: stall_o = start;
      REQ: begin
        stall_o      = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_we_o    = store_q;
        dmem_addr_o  = {addr_q, 2'b00};
        dmem_wdata_o = wdata_q;
        dmem_wstrb_o = wstrb_q;
      end
      WAIT: stall_o = 1'b1;
      default: begin
        load_valid_o = (result_q == RES_LOAD);
        misalign_o   = (result_q == RES_MISALIGN);
        err_o        = (result_q == RES_ERR);
      end
    endcase
  end

  // Access capture, watchdog and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      offset_q    <= 2'b00;
      funct3_q    <= 3'b000;
      store_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      wstrb_q     <= WSTRB_NONE;
      load_data_q <= 32'h0;
    end else begin
      if (state_q == IDLE && start) begin
        offset_q <= addr_i[1:0];
        funct3_q <= funct3_i;
        store_q  <= mem_store_i;
        addr_q   <= addr_i[31:2];
        wdata_q  <= mem_store_i ? wdata_fmt : 32'h0;
        wstrb_q  <= mem_store_i ? wstrb_fmt : WSTRB_NONE;
      end
      // REQ is only entered from IDLE, so clearing here clears on entry.
      if (state_q == IDLE)
        cnt_q <= '0;
      else if (state_q == REQ || state_q == WAIT)
        cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == WAIT && dmem_rvalid_i)
        load_data_q <= aligned;
    end
  end

  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit. "dut" runs without a
// watchdog; "dut_to" uses TIMEOUT_CYCLES = 4 with a memory that never grants.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_valid_to, mem_load, mem_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  logic        stall, load_valid, misalign, err, req, we;
  logic [31:0] load_data, daddr, wdata;
  logic [3:0]  wstrb;

  logic        stall_to, load_valid_to, misalign_to, err_to, req_to, we_to;
  logic [31:0] load_data_to, daddr_to, wdata_to;
  logic [3:0]  wstrb_to;
  logic        gnt_to, rvalid_to;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit dut (
    .clk (clk), .rst (rst),
    .mem_valid_i (mem_valid), .mem_load_i (mem_load), .mem_store_i (mem_store),
    .funct3_i (funct3), .addr_i (addr), .store_data_i (store_data),
    .stall_o (stall), .load_valid_o (load_valid), .load_data_o (load_data),
    .misalign_o (misalign), .err_o (err),
    .dmem_req_o (req), .dmem_we_o (we), .dmem_addr_o (daddr),
    .dmem_wdata_o (wdata), .dmem_wstrb_o (wstrb),
    .dmem_gnt_i (gnt), .dmem_rvalid_i (rvalid), .dmem_rdata_i (rdata)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_to (
    .clk (clk), .rst (rst),
    .mem_valid_i (mem_valid_to), .mem_load_i (mem_load), .mem_store_i (mem_store),
    .funct3_i (funct3), .addr_i (addr), .store_data_i (store_data),
    .stall_o (stall_to), .load_valid_o (load_valid_to), .load_data_o (load_data_to),
    .misalign_o (misalign_to), .err_o (err_to),
    .dmem_req_o (req_to), .dmem_we_o (we_to), .dmem_addr_o (daddr_to),
    .dmem_wdata_o (wdata_to), .dmem_wstrb_o (wstrb_to),
    .dmem_gnt_i (gnt_to), .dmem_rvalid_i (rvalid_to), .dmem_rdata_i (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here and
  // outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    mem_valid  = v;
    mem_load   = ld;
    mem_store  = st;
    funct3     = f3;
    addr       = a;
    store_data = d;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    gnt    = 1'b0;
    rvalid = 1'b0;
  endtask

  // Load with same-cycle grant and rvalid on the following cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0);
    #1 check({tag, " idle stall"}, stall, 1);
    check({tag, " idle no req"}, req, 0);
    step();
    gnt = 1'b1;
    #1 check({tag, " req"}, req, 1);
    check({tag, " addr"}, daddr, {a[31:2], 2'b00});
    check({tag, " we"}, we, 0);
    check({tag, " wstrb"}, wstrb, 0);
    check({tag, " req stall"}, stall, 1);
    step();
    gnt = 1'b0; rvalid = 1'b1; rdata = rd;
    #1 check({tag, " wait stall"}, stall, 1);
    check({tag, " wait no req"}, req, 0);
    step();
    rvalid = 1'b0; rdata = 32'h0;
    #1 check({tag, " resp stall"}, stall, 0);
    check({tag, " load_valid"}, load_valid, 1);
    check({tag, " load_data"}, load_data, exp);
    step();
    idle_inputs();
    #1 check({tag, " pulse ends"}, load_valid, 0);
    check({tag, " data held"}, load_data, exp);
  endtask

  // Store with grant delayed by gnt_delay cycles inside REQ.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input int gnt_delay,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
    drive(1'b1, 1'b0, 1'b1, f3, a, d);
    #1 check({tag, " idle stall"}, stall, 1);
    step();
    for (int i = 0; i <= gnt_delay; i++) begin
      gnt = (i == gnt_delay);
      #1 check({tag, " req held"}, req, 1);
      check({tag, " we"}, we, 1);
      check({tag, " addr"}, daddr, {a[31:2], 2'b00});
      check({tag, " wdata"}, wdata, exp_wdata);
      check({tag, " wstrb"}, {28'h0, wstrb}, {28'h0, exp_wstrb});
      check({tag, " stall"}, stall, 1);
      step();
    end
    gnt = 1'b0;
    #1 check({tag, " resp stall"}, stall, 0);
    check({tag, " resp no req"}, req, 0);
    check({tag, " no load_valid"}, load_valid, 0);
    check({tag, " no misalign"}, misalign, 0);
    check({tag, " no err"}, err, 0);
    step();
    idle_inputs();
  endtask

  // Faulting access: one stall cycle, never reaches the port.
  task automatic do_fault(input string tag, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic exp_mis, input logic exp_err);
    drive(1'b1, ld, st, f3, a, 32'h1234_5678);
    #1 check({tag, " idle stall"}, stall, 1);
    check({tag, " no req"}, req, 0);
    step();
    #1 check({tag, " resp stall"}, stall, 0);
    check({tag, " resp no req"}, req, 0);
    check({tag, " misalign"}, misalign, exp_mis);
    check({tag, " err"}, err, exp_err);
    check({tag, " no load_valid"}, load_valid, 0);
    step();
    idle_inputs();
    #1 check({tag, " pulses end"}, {30'h0, misalign, err}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst = 1'b1;
    mem_valid_to = 1'b0;
    gnt_to = 1'b0;
    rvalid_to = 1'b0;
    rdata = 32'h0;
    idle_inputs();
    step();
    step();
    check("reset stall", stall, 0);
    check("reset req", req, 0);
    check("reset load_data", load_data, 0);
    check("reset pulses", {29'h0, load_valid, misalign, err}, 0);
    check("reset addr", daddr, 0);
    rst = 1'b0;
    step();

    // Non-memory instruction never stalls
    drive(1'b1, 1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    #1 check("alu stall", stall, 0);
    step();
    check("alu stall next", stall, 0);
    check("alu no req", req, 0);
    idle_inputs();
    step();

    do_load("LW 0x100", 3'b010, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("LB 0x103", 3'b000, 32'h103, 32'h80FF_1234, 32'hFFFF_FF80);
    do_load("LBU 0x103", 3'b100, 32'h103, 32'h80FF_1234, 32'h0000_0080);
    do_load("LHU 0x102", 3'b101, 32'h102, 32'h80FF_1234, 32'h0000_80FF);
    do_load("LH 0x102", 3'b001, 32'h102, 32'h80FF_1234, 32'hFFFF_80FF);
    do_load("LB 0x101", 3'b000, 32'h101, 32'h80FF_1234, 32'h0000_0012);

    do_store("SB 0x202", 3'b000, 32'h202, 32'h0000_00A5, 4, 32'hA5A5_A5A5, 4'b0100);
    do_store("SH 0x302", 3'b001, 32'h302, 32'h1234_BEEF, 0, 32'hBEEF_BEEF, 4'b1100);
    do_store("SW 0x404", 3'b010, 32'h404, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 4'b1111);

    do_fault("SH 0x001", 1'b0, 1'b1, 3'b001, 32'h001, 1'b1, 1'b0);
    do_fault("LW 0x006", 1'b1, 1'b0, 3'b010, 32'h006, 1'b1, 1'b0);
    do_fault("load f3 011", 1'b1, 1'b0, 3'b011, 32'h000, 1'b0, 1'b1);
    do_fault("store f3 100", 1'b0, 1'b1, 3'b100, 32'h000, 1'b0, 1'b1);
    do_fault("load+store", 1'b1, 1'b1, 3'b010, 32'h000, 1'b0, 1'b1);

    // Watchdog: no grant ever, 4 REQ cycles then err
    drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    mem_valid_to = 1'b1;
    #1 check("wdog idle stall", stall_to, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      check("wdog req held", req_to, 1);
      check("wdog stall", stall_to, 1);
      check("wdog no err yet", err_to, 0);
      step();
    end
    check("wdog req dropped", req_to, 0);
    check("wdog err", err_to, 1);
    check("wdog stall released", stall_to, 0);
    check("wdog no load_valid", load_valid_to, 0);
    step();
    mem_valid_to = 1'b0;
    idle_inputs();
    #1 check("wdog err ends", err_to, 0);
    check("main dut untouched", stall, 0);

    // Reset while waiting for read data
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h80, 32'h0);
    step();
    gnt = 1'b1;
    step();
    gnt = 1'b0;
    #1 check("rst-wait stall", stall, 1);
    rst = 1'b1;
    idle_inputs();
    step();
    check("rst-wait stall cleared", stall, 0);
    check("rst-wait req", req, 0);
    check("rst-wait load_data", load_data, 0);
    check("rst-wait pulses", {29'h0, load_valid, misalign, err}, 0);
    check("rst-wait wstrb", {28'h0, wstrb}, 0);
    rst = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h1234_5678;
    step();
    rvalid = 1'b0;
    #1 check("late rvalid no load_valid", load_valid, 0);
    check("late rvalid data", load_data, 0);
    check("late rvalid stall", stall, 0);
    step();
    check("late rvalid after", load_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage of the rv32im pipeline. It sits directly downstream of the execute stage, behind the EX/MEM register.
- Consumes the execute ALU result as the effective address, plus the store operand and funct3.
- Drives a valid/grant/rvalid data-memory port, performs byte/halfword alignment and sign/zero extension, and stalls the pipeline until the access completes.
- Flags misaligned or illegal accesses and bus timeouts instead of issuing them.

Parameters:
- TIMEOUT_CYCLES, 0, cycles to wait for dmem_gnt_i or dmem_rvalid_i before aborting with err_o; 0 disables the watchdog.
- CNT_W, 8, width of the watchdog counter; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- mem_valid_i  in  1  EX/MEM holds a valid instruction
- mem_load_i  in  1  instruction is a load
- mem_store_i  in  1  instruction is a store
- funct3_i  in  3  access size/sign (RV32I encoding)
- addr_i  in  32  effective address (execute ALU result)
- store_data_i  in  32  rs2 value for stores
- stall_o  out  1  hold the pipeline (EX/MEM and upstream)
- load_valid_o  out  1  one-cycle pulse; load_data_o is valid
- load_data_o  out  32  aligned, extended load result
- misalign_o  out  1  one-cycle pulse; misaligned access
- err_o  out  1  one-cycle pulse; illegal funct3, load and store both set, or timeout
- dmem_req_o  out  1  memory request valid
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, bits [1:0] = 0
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_wstrb_o  out  4  byte enables; 0 for reads
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid; never in the same cycle as its grant
- dmem_rdata_i  in  32  read data word

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including stall_o.
  - Watchdog counter and the captured offset/funct3/rdata registers cleared.
  - Reset mid-transaction abandons it; the memory side is reset by the same rst.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - start = mem_valid_i & (mem_load_i | mem_store_i).
  - On start, stall_o = 1 combinationally, and the unit latches addr[1:0], funct3, the load/store flag, wdata and wstrb.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]≠0) -> RESP with misalign_o pending.
  - Illegal access -> RESP with err_o pending. Illegal means load funct3 ∈ {011,110,111}, store funct3 ∉ {000,001,010}, or load and store both set.
  - Otherwise -> REQ.
- REQ:
  - dmem_req_o = 1; address, data, strobes and we are held stable; stall_o = 1.
  - On dmem_gnt_i: store -> RESP, load -> WAIT.
- WAIT:
  - stall_o = 1.
  - On dmem_rvalid_i, capture dmem_rdata_i -> RESP.
- RESP:
  - stall_o = 0, so the pipeline advances at the edge ending this cycle.
  - Exactly one of these pulses for the cycle: load_valid_o (successful load), misalign_o, or err_o. A successful store pulses none.
  - Always -> IDLE. The still-presented instruction is not re-accepted because acceptance happens only in IDLE.
- Watchdog (only when TIMEOUT_CYCLES ≠ 0):
  - Counts cycles spent in REQ or WAIT and clears on entry to REQ.
  - Reaching TIMEOUT_CYCLES -> RESP with err_o; dmem_req_o drops.
- Store formatting:
  - SB: wdata = {4{b}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, wstrb = 0011 << {addr[1],1'b0}.
  - SW: wdata = data, wstrb = 1111.
- Load extraction uses the latched offset:
  - LB / LBU: byte sign- or zero-extended.
  - LH / LHU: halfword sign- or zero-extended.
  - LW: full word.
- load_data_o holds its last value outside RESP; it is 0 after reset.
- Latency:
  - Minimum load stall is 3 cycles (IDLE, REQ with same-cycle grant, WAIT with rvalid next cycle); the result is in RESP.
  - Minimum store stall is 2 cycles.
  - A fault stalls for 1 cycle.
  - Non-memory instructions never stall.

Decomposition:
- Shared package rv_mem_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), the state enum, and the wstrb constants.
- One natural combinational sub-module: mem_load_align (rdata, offset, funct3 -> load_data).

Test Plan:
- LW at addr 0x100; gnt in REQ cycle, rdata 0xDEADBEEF next cycle -> dmem_addr_o 0x100, stall 3 cycles, RESP load_data_o = 0xDEADBEEF, load_valid_o = 1.
- LB at 0x103 with rdata 0x80FF_1234 -> load_data_o 0xFFFFFF80; LBU -> 0x00000080; LHU at 0x102 -> 0x000080FF.
- SB of 0x000000A5 at 0x0202, gnt delayed 4 cycles -> wdata 0xA5A5A5A5, wstrb 0100, dmem_addr_o 0x200, req held stable 5 cycles, no load_valid_o.
- SH at 0x0001 and LW at 0x0006 -> no dmem_req_o, 1-cycle stall, misalign_o pulse; funct3 011 load -> err_o pulse.
- TIMEOUT_CYCLES = 4, gnt never asserted -> req drops after 4 REQ cycles, err_o pulse, stall released.
- rst asserted while in WAIT -> next cycle state IDLE, stall_o = 0, all outputs 0; a later rvalid is ignored.
